arb_out_fifo: RTL
=================

Name: arb_out_fifo

Overview:
- Downstream buffer stage for the T-input arbiter.
- Captures every beat the arbiter presents on its t_data_o/t_valid_o outputs. The arbiter has no back-pressure input, so this block must absorb its output stream.
- Re-presents the beats to the consumer over a valid/ready handshake, in first-word-fall-through order.
- Drops and flags any beat that arrives while the buffer is full and no pop frees a slot.

Parameters:
- BIT_DEPTH, 8, data width in bits; must match the arbiter's BIT_DEPTH.
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count. Derived; not to be overridden.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high.
- t_data_i  input  BIT_DEPTH  beat from the arbiter's t_data_o.
- t_valid_i  input  1  beat-valid from the arbiter's t_valid_o.
- m_data_o  output  BIT_DEPTH  head-of-queue data.
- m_valid_o  output  1  head entry present.
- m_ready_i  input  1  consumer accepts the head entry.
- full_o  output  1  count == DEPTH.
- empty_o  output  1  count == 0.
- count_o  output  CNT_W  current occupancy, 0..DEPTH.
- overflow_o  output  1  one-cycle pulse; a beat was dropped in the previous cycle.

Interface rule (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst sampled high at posedge):
  - wr_ptr, rd_ptr, count cleared.
  - m_valid_o=0, empty_o=1, full_o=0, count_o=0, overflow_o=0.
  - Storage array is not cleared.
  - m_data_o is don't-care while m_valid_o=0.
  - rst dominates push and pop in the same cycle. A reset mid-stream discards all held entries; the next beat after reset is accepted normally.
- Pointers:
  - Width $clog2(DEPTH)+1. Low bits index storage; the MSB is the wrap bit.
  - Both pointers increment modulo 2*DEPTH, so wrap-around is seamless.
  - empty: pointers equal. full: low bits equal and MSBs differ.
- pop: m_valid_o && m_ready_i.
  - m_ready_i while empty is ignored; no state change.
- push: t_valid_i && (!full_o || pop).
  - When full with a simultaneous pop, the new beat is written into the freed slot. count stays DEPTH; full_o stays 1.
- drop: t_valid_i && full_o && !pop.
  - Beat discarded; no state change.
  - overflow_o=1 on the following cycle only.
  - Back-to-back drops give consecutive overflow pulses.
- Data ordering: m_data_o = mem[rd_ptr]. This is FWFT: the head is visible without a pop.
- Latency: a beat pushed at edge k appears at m_data_o/m_valid_o after edge k. There is no combinational bypass from t_data_i to m_data_o.
- Empty with push in the same cycle: no pop is possible (m_valid_o=0). Next cycle count=1 and m_valid_o=1.
- count update: +1 on push-only, -1 on pop-only, unchanged on push+pop or idle.
- Status outputs: full_o, empty_o and m_valid_o are derived from registered state only, with no input-to-output combinational paths. count_o is registered.
- Sustained traffic: throughput of one beat per cycle when t_valid_i and m_ready_i are held high.

Optional Feature:
- Macro: ARB_OUT_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o, 8 bits.
  - Increments on every drop and saturates at 255.
  - Cleared by rst.
  - drop_cnt_o updates on the same edge that raises overflow_o.
- Undefined: port and counter absent. overflow_o is still present and unchanged.

Test Plan:
- Reset then idle: rst held 2 cycles, released -> empty_o=1, full_o=0, count_o=0, m_valid_o=0, overflow_o=0.
- Arbiter-like burst, m_ready_i=0: push 10, 11, 12, 13 on consecutive cycles -> count_o goes 1, 2, 3, 4; full_o=1 after the 4th; m_data_o=10 throughout. Then raise m_ready_i -> pops 10, 11, 12, 13 in order; empty_o=1 after the last pop.
- Overflow, DEPTH=4 full with m_ready_i=0: push 14 -> dropped; overflow_o=1 for exactly one cycle; count_o stays 4; head still 10. With the macro defined, drop_cnt_o=1.
- Full with simultaneous push+pop: push 20 while m_ready_i=1 -> 10 popped, 20 written; count_o=4; overflow_o=0; drain order 11, 12, 13, 20.
- Streaming wrap: t_valid_i and m_ready_i held high for 10 beats, data 0..9 -> output 0..9 with 1-cycle latency; count_o never exceeds 1; no overflow; pointers wrap twice.
- Reset mid-operation: 3 entries held, assert rst with t_valid_i=1 and data 30 in the same cycle -> after the edge count_o=0, m_valid_o=0, 30 not stored. Next push of 31 -> m_data_o=31, count_o=1.

Source files
------------

// File: rtl/arb_out_fifo.sv
// Output buffer for the T-input arbiter: absorbs every arbiter beat and re-presents it FWFT over valid/ready.
// Optional macro ARB_OUT_FIFO_DROP_CNT_EN adds a saturating 8-bit dropped-beat counter (drop_cnt_o).
module arb_out_fifo #(
    parameter int BIT_DEPTH = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_DEPTH-1:0] t_data_i,
    input  logic                 t_valid_i,
    output logic [BIT_DEPTH-1:0] m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_W-1:0]     count_o,
`ifdef ARB_OUT_FIFO_DROP_CNT_EN
    output logic [7:0]           drop_cnt_o,
`endif
    output logic                 overflow_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [BIT_DEPTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 drop;

    // Status comes from registered pointers only; the wrap bit separates full from empty.
    assign empty_o   = (wr_ptr == rd_ptr);
    assign full_o    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign m_valid_o = !empty_o;
    assign m_data_o  = mem[rd_ptr[AW-1:0]];

    assign pop  = m_valid_o && m_ready_i;
    assign push = t_valid_i && (!full_o || pop);
    assign drop = t_valid_i && full_o && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= t_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= drop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

`ifdef ARB_OUT_FIFO_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_o <= '0;
        end else if (drop && (drop_cnt_o != 8'hFF)) begin
            drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end
`endif

endmodule
